spi_transmit: RTL and testbench
===============================

Name: spi_transmit

Overview:
- SPI master transmitter. Reads a block of 16-bit words from a synchronous single-port RAM and shifts each word out MSB-first on mosi/sclk.
- Forms the far end of the 16-bit SPI word link: the peer receiver samples mosi on sclk rising edges and counts 16 bits per word with no other framing.
- Runs entirely on the system clock clk; sclk is generated internally by a divider.

Parameters:
- CLK_DIV, 4, sclk half-period in clk cycles; minimum 1. sclk frequency = clk/(2*CLK_DIV).
- DATA_W, 16, word width; fixed at 16 by the link, parameterised for the package only.
- ADDR_W, 15, memory address width.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- start_addr  in  ADDR_W  first word address, latched on accepted start
- word_count  in  16  number of words to send, latched on accepted start
- mem_addr  out  ADDR_W  RAM read address
- mem_rd  out  1  RAM read strobe; data valid on mem_data the following cycle
- mem_data  in  DATA_W  RAM read data
- sclk  out  1  SPI clock; idles low
- mosi  out  1  serial data; changes only while sclk is low
- cs_n  out  1  frame select; low for the whole burst
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of burst
- words_sent  out  16  words completed in the current/last burst

Behaviour:
- Reset (async): state IDLE, sclk=0, mosi=0, cs_n=1, mem_rd=0, mem_addr=0, busy=0, done=0, words_sent=0. Shift register and bit count cleared. Asserting reset mid-word aborts immediately with no trailing sclk edge.
- States:
  - IDLE -> FETCH on start when word_count != 0.
  - IDLE -> FINISH on start when word_count == 0; no sclk edges occur.
  - FETCH -> LOAD -> SHIFT.
  - SHIFT -> FETCH after bit 16 if words remain; otherwise SHIFT -> FINISH.
  - FINISH -> IDLE.
- Accepted start: latch start_addr into mem_addr and word_count into remaining; clear words_sent; busy=1 and cs_n=0 from the next cycle.
- FETCH (1 cycle): mem_rd=1 with the current mem_addr.
- LOAD (1 cycle): capture mem_data into the 16-bit shift register; increment mem_addr, wrapping at 2^ADDR_W-1 -> 0.
- SHIFT:
  - mosi = shreg[15].
  - Each bit is sclk low for CLK_DIV cycles, then sclk high for CLK_DIV cycles.
  - At the end of the high phase: sclk -> 0, shreg shifts left, bit_cnt increments.
  - After the 16th high phase: words_sent increments and remaining decrements.
- Per-word cost: 2 + 32*CLK_DIV cycles. Between words, sclk is held low for the 2 fetch cycles; the receiver is edge-counted, so the gap is legal.
- FINISH (1 cycle): cs_n=1, busy=0, done=1 registered, so the pulse is visible on the cycle the block returns to IDLE. words_sent holds its value until the next accepted start.
- start while busy: ignored. start in the same cycle done is high: block is in IDLE, so start is accepted.
- word_count=0xFFFF: legal. Counters are 16-bit with no overflow; remaining reaches 0 exactly.

Decomposition:
- Package spi_pkg: SPI_DATA_W=16, SPI_ADDR_W=15, and the typedef enum tx_state_t {IDLE, FETCH, LOAD, SHIFT, FINISH}. The peer receiver shares the width constants.
- Sub-module spi_clk_gen: half-period counter with enable. Outputs sclk plus rise_stb and fall_stb one-cycle strobes; counter and sclk are reset when disabled. spi_transmit holds the FSM, shift register, counters and memory interface.

Test Plan:
- CLK_DIV=2, start_addr=0, word_count=1, RAM[0]=0xA5C3 -> mosi sampled on sclk rises = 1010010111000011; exactly 16 rises; done pulses once; words_sent=1; cs_n low only during the burst.
- word_count=3, RAM[5..7]=0x0001,0x8000,0xFFFF, start_addr=5 -> 48 rises; bitstreams match; mem_rd pulses 3 times at addresses 5,6,7; sclk low for 2 clk between words.
- word_count=0 -> no sclk edge, no mem_rd, done high 2 cycles after start, words_sent=0.
- start_addr=0x7FFF, word_count=2 -> reads at 0x7FFF then 0x0000.
- Reset asserted at bit 7 of word 2 -> same-cycle sclk=0, cs_n=1, busy=0; a new start then sends correctly from the first bit.
- start pulsed while busy -> ignored; burst length and words_sent unchanged. Loopback to the peer receiver model reproduces RAM contents.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared widths and transmitter state encoding for the 16-bit SPI word link
package spi_pkg;
    localparam int SPI_DATA_W = 16;
    localparam int SPI_ADDR_W = 15;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, FINISH} tx_state_t;
endpackage

// File: rtl/spi_transmit_clk_gen.sv
// spi_clk_gen: sclk divider with rise/fall strobes, held low and cleared while disabled
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_stb = wrap && !sclk;
    assign fall_stb = wrap && sclk;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + CW'(1);
        end
endmodule

// File: rtl/spi_transmit.sv
// spi_transmit: SPI master that streams a block of RAM words out MSB-first on mosi/sclk
module spi_transmit
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_DATA_W,
    parameter int ADDR_W  = SPI_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_sent
);
    localparam int BW = $clog2(DATA_W);
    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [15:0]       remaining;
    logic              last_bit;
    logic              rise_stb;
    logic              fall_stb;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (state == SHIFT),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    assign mosi   = shreg[DATA_W-1];
    assign mem_rd = (state == FETCH);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            mem_addr   <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            last_bit   <= 1'b0;
            remaining  <= '0;
            words_sent <= '0;
            busy       <= 1'b0;
            cs_n       <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mem_addr   <= start_addr;
                    remaining  <= word_count;
                    words_sent <= '0;
                    busy       <= 1'b1;
                    cs_n       <= 1'b0;
                    state      <= (word_count == 16'd0) ? FINISH : FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shreg    <= mem_data;
                    mem_addr <= mem_addr + ADDR_W'(1);
                    bit_cnt  <= '0;
                    last_bit <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    // arm word completion on the final rise so the fall that follows closes the word
                    if (rise_stb && bit_cnt == BW'(DATA_W - 1))
                        last_bit <= 1'b1;
                    if (fall_stb) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (last_bit) begin
                            words_sent <= words_sent + 16'd1;
                            remaining  <= remaining - 16'd1;
                            state      <= (remaining == 16'd1) ? FINISH : FETCH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    cs_n  <= 1'b1;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spi_transmit.sv
// tb_spi_transmit: directed bursts with a bit/address scoreboard acting as the peer receiver
module tb_spi_transmit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] start_addr = '0;
    logic [15:0] word_count = '0;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data = '0;
    logic        sclk, mosi, cs_n, busy, done;
    logic [15:0] words_sent;

    logic [15:0] ram [0:32767];
    logic        exp_bits [$];
    logic [14:0] exp_addr [$];
    int passed = 0, total = 0;
    int rises = 0, rd_pulses = 0, done_pulses = 0;
    logic sclk_q = 1'b0;

    spi_transmit #(.CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .word_count(word_count), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
        .busy(busy), .done(done), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // peer receiver: samples mosi on each sclk rise, plus read-port bookkeeping
    always @(negedge clk) begin
        if (sclk && !sclk_q) begin
            rises++;
            chk("cs_n_at_rise", cs_n, 0);
            if (exp_bits.size() > 0) chk("mosi", mosi, exp_bits.pop_front());
        end
        if (mem_rd) begin
            rd_pulses++;
            chk("sclk_low_in_fetch", sclk, 0);
            if (exp_addr.size() > 0) chk("mem_addr", mem_addr, exp_addr.pop_front());
        end
        if (done) done_pulses++;
        sclk_q = sclk;
    end

    task automatic burst(input logic [14:0] a, input logic [15:0] n, input bit poke);
        int r0, d0, m0, cyc, lim;
        logic [14:0] aw;
        for (int w = 0; w < int'(n); w++) begin
            aw = a + 15'(w);
            exp_addr.push_back(aw);
            for (int b = 15; b >= 0; b--) exp_bits.push_back(ram[aw][b]);
        end
        r0 = rises; d0 = done_pulses; m0 = rd_pulses;
        lim = 66 * int'(n) + 50;
        @(negedge clk); #1;
        start = 1'b1; start_addr = a; word_count = n;
        @(negedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("cs_n_after_start", cs_n, 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < lim) begin
            @(negedge clk); #1;
            cyc++;
            if (poke) begin
                start = (cyc == 20);
                if (cyc == 20) begin start_addr = 15'h1234; word_count = 16'd9; end
            end
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("burst_cycles", cyc, 66 * int'(n) + 1);
        chk("busy_end", busy, 0);
        chk("cs_n_end", cs_n, 1);
        chk("words_sent", words_sent, n);
        chk("rise_count", rises - r0, 16 * int'(n));
        chk("rd_count", rd_pulses - m0, n);
        chk("bits_left", exp_bits.size(), 0);
        @(negedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("done_pulses", done_pulses - d0, 1);
        chk("words_sent_hold", words_sent, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r0, cyc;
        for (int i = 0; i < 32768; i++) ram[i] = 16'($urandom);
        ram[0] = 16'hA5C3;
        ram[5] = 16'h0001; ram[6] = 16'h8000; ram[7] = 16'hFFFF;
        ram[15'h7FFF] = 16'h3C5A;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words_sent", words_sent, 0);
        reset = 1'b0;
        burst(15'd0, 16'd1, 1'b0);
        burst(15'd5, 16'd3, 1'b0);
        burst(15'd0, 16'd0, 1'b0);
        burst(15'h7FFF, 16'd2, 1'b0);
        burst(15'd200, 16'd3, 1'b1);
        // abort in the middle of word 2, bit 7
        r0 = rises;
        @(negedge clk); #1;
        start = 1'b1; start_addr = 15'd0; word_count = 16'd3;
        @(negedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (rises - r0 < 23 && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("abort_reached_bit", rises - r0, 23);
        chk("abort_sclk_high", sclk, 1);
        reset = 1'b1;
        #1;
        chk("abort_sclk", sclk, 0);
        chk("abort_cs_n", cs_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_words_sent", words_sent, 0);
        @(negedge clk); #1;
        reset = 1'b0;
        exp_bits.delete();
        exp_addr.delete();
        burst(15'd0, 16'd3, 1'b0);
        burst(15'd100, 16'd4, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
